// File: rtl/clk_phase_gen.sv
// clk_phase_gen -- multi-channel counter-based clock generator.
//
// Derives NUM_CH clocks from the reference clock clk. Each channel has a
// programmable divide, high time and phase offset in whole clk cycles. All
// channels realign together and lock is reported after LOCK_CYCLES quiet
// edges following a realignment.
//
// Ports:
//   clk        reference clock, rising edge
//   RST        asynchronous reset, active-high
//   PWRDWN     synchronous power-down, active-high
//   cfg_we     configuration write strobe
//   cfg_ch     target channel of the write
//   cfg_div    divide (>= 2)
//   cfg_high   high count (1 .. div-1)
//   cfg_phase  phase offset (0 .. div-1)
//   cfg_err    one-cycle pulse when a write is rejected
//   ps_en      dynamic phase-step request
//   ps_ch      phase-step channel
//   ps_incdec  1 = delay one clk cycle, 0 = advance one clk cycle
//   ps_done    one-cycle phase-step completion pulse
//   clk_out    generated clocks
//   lock       all channels aligned and stable
//
// Build option: define CLK_PHASE_GEN_DPS_EN to enable dynamic phase stepping.
// Without it the ps_* inputs are ignored and ps_done stays 0.

module clk_phase_gen #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned LOCK_CYCLES = 64,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              PWRDWN,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_high,
  input  logic [CNT_W-1:0]  cfg_phase,
  output logic              cfg_err,
  input  logic              ps_en,
  input  logic [CH_W-1:0]   ps_ch,
  input  logic              ps_incdec,
  output logic              ps_done,
  output logic [NUM_CH-1:0] clk_out,
  output logic              lock
);

  localparam int unsigned LK_W = $clog2(LOCK_CYCLES + 1);

  // ST_PD doubles as the reset state: leaving it always realigns, which gives
  // the realignment on the first edge after RST is released.
  typedef enum logic [1:0] {
    ST_PD,
    ST_UNLOCKED,
    ST_LOCKED
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] div_q   [NUM_CH];
  logic [CNT_W-1:0] high_q  [NUM_CH];
  logic [CNT_W-1:0] phase_q [NUM_CH];
  logic [CNT_W-1:0] cnt_q   [NUM_CH];
  logic [LK_W-1:0]  lock_cnt_q;

  logic wr_valid;
  logic realign;
  logic hold;
  logic run;

  logic            ps_apply;
  logic [CH_W-1:0] ps_ch_q;
  logic            ps_dir_q;

  assign wr_valid = cfg_we
                 && (cfg_div >= CNT_W'(2))
                 && (cfg_high != '0)
                 && (cfg_high < cfg_div)
                 && (cfg_phase < cfg_div)
                 && (32'(cfg_ch) < NUM_CH);

  assign lock = (state_q == ST_LOCKED);

  // Lock-state register
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q <= ST_PD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and realignment decision
  always_comb begin
    state_d = state_q;
    realign = 1'b0;
    case (state_q)
      ST_PD: begin
        if (!PWRDWN) begin
          state_d = ST_UNLOCKED;
          realign = 1'b1;
        end
      end
      ST_UNLOCKED: begin
        if (PWRDWN) begin
          state_d = ST_PD;
        end else if (wr_valid) begin
          realign = 1'b1;
        end else if (lock_cnt_q == LK_W'(LOCK_CYCLES - 1)) begin
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (PWRDWN) begin
          state_d = ST_PD;
        end else if (wr_valid) begin
          state_d = ST_UNLOCKED;
          realign = 1'b1;
        end
      end
      default: state_d = ST_PD;
    endcase
  end

  assign hold = (state_d == ST_PD);
  assign run  = !realign && !hold;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      lock_cnt_q <= '0;
    end else if (realign) begin
      lock_cnt_q <= '0;
    end else if (run && (state_q == ST_UNLOCKED)) begin
      lock_cnt_q <= lock_cnt_q + LK_W'(1);
    end
  end

`ifdef CLK_PHASE_GEN_DPS_EN
  logic ps_pend_q;
  logic ps_fin_q;
  logic ps_accept;

  // A step is taken only from a locked, otherwise idle edge; any cfg_we on
  // the same edge wins over the step request.
  assign ps_accept = ps_en && (state_q == ST_LOCKED) && !ps_pend_q && !ps_fin_q
                  && (32'(ps_ch) < NUM_CH) && !cfg_we && !PWRDWN;
  assign ps_apply  = ps_pend_q && run;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      ps_pend_q <= 1'b0;
      ps_fin_q  <= 1'b0;
      ps_ch_q   <= '0;
      ps_dir_q  <= 1'b0;
      ps_done   <= 1'b0;
    end else begin
      ps_pend_q <= ps_accept;
      ps_fin_q  <= ps_apply;
      ps_done   <= ps_fin_q;
      if (ps_accept) begin
        ps_ch_q  <= ps_ch;
        ps_dir_q <= ps_incdec;
      end
    end
  end
`else
  logic unused_ps;

  assign unused_ps = ^{ps_en, ps_ch, ps_incdec};
  assign ps_apply  = 1'b0;
  assign ps_ch_q   = '0;
  assign ps_dir_q  = 1'b0;
  assign ps_done   = 1'b0;
`endif

  // Per-channel next values
  logic [NUM_CH-1:0] sel_wr;
  logic [NUM_CH-1:0] sel_ps;
  logic [CNT_W-1:0]  align_val   [NUM_CH];
  logic [CNT_W-1:0]  cnt_next    [NUM_CH];
  logic [CNT_W-1:0]  phase_step  [NUM_CH];

  always_comb begin
    logic [CNT_W-1:0] div_eff;
    logic [CNT_W-1:0] ph_eff;
    logic [CNT_W:0]   sum2;
    div_eff = '0;
    ph_eff  = '0;
    sum2    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      sel_wr[i] = wr_valid && (cfg_ch == CH_W'(i));
      sel_ps[i] = ps_apply && (ps_ch_q == CH_W'(i));

      // Realignment uses the values being written on this same edge.
      div_eff      = sel_wr[i] ? cfg_div   : div_q[i];
      ph_eff       = sel_wr[i] ? cfg_phase : phase_q[i];
      align_val[i] = (ph_eff == '0) ? '0 : div_eff - ph_eff;

      // Advance step skips one count; since cnt < div and div >= 2 a single
      // subtraction brings the sum back into range.
      sum2 = {1'b0, cnt_q[i]} + (CNT_W + 1)'(2);
      if (sel_ps[i] && ps_dir_q) begin
        cnt_next[i] = cnt_q[i];
      end else if (sel_ps[i]) begin
        cnt_next[i] = (sum2 >= {1'b0, div_q[i]}) ? CNT_W'(sum2 - {1'b0, div_q[i]})
                                                  : sum2[CNT_W-1:0];
      end else begin
        cnt_next[i] = (cnt_q[i] == div_q[i] - CNT_W'(1)) ? '0 : cnt_q[i] + CNT_W'(1);
      end

      if (ps_dir_q) begin
        phase_step[i] = (phase_q[i] == div_q[i] - CNT_W'(1)) ? '0 : phase_q[i] + CNT_W'(1);
      end else begin
        phase_step[i] = (phase_q[i] == '0) ? div_q[i] - CNT_W'(1) : phase_q[i] - CNT_W'(1);
      end
    end
  end

  // Channel registers, counters and outputs
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      cfg_err <= 1'b0;
      clk_out <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        div_q[i]   <= CNT_W'(2);
        high_q[i]  <= CNT_W'(1);
        phase_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      cfg_err <= cfg_we && !wr_valid;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (sel_wr[i]) begin
          div_q[i]   <= cfg_div;
          high_q[i]  <= cfg_high;
          phase_q[i] <= cfg_phase;
        end else if (sel_ps[i]) begin
          phase_q[i] <= phase_step[i];
        end

        if (realign) begin
          cnt_q[i]   <= align_val[i];
          clk_out[i] <= 1'b0;
        end else if (hold) begin
          clk_out[i] <= 1'b0;
        end else begin
          clk_out[i] <= (cnt_q[i] < high_q[i]);
          cnt_q[i]   <= cnt_next[i];
        end
      end
    end
  end

endmodule

// File: doc/clk_phase_gen.md
# clk_phase_gen

Multi-channel counter-based clock generator for the PLL/MMCM simulation models. From a single fast reference clock `clk` (the VCO-rate clock), it derives `NUM_CH` output clocks, each with its own programmable divide, high time and phase offset in whole `clk` cycles. All channels are phase-aligned on a common realignment edge, and the block reports `lock`. It replaces per-output delay-based shifting with cycle-accurate, synthesizable counters and adds optional dynamic phase stepping.

## Interface
- `NUM_CH`, default 4: number of output channels (1..16).
- `CNT_W`, default 8: width of the divide, high and phase fields.
- `LOCK_CYCLES`, default 64: `clk` edges from realignment to `lock` rising (≥1).
- `clk`, input, 1: reference clock; all logic is on the rising edge.
- `RST`, input, 1: asynchronous reset, active-high.
- `PWRDWN`, input, 1: synchronous power-down, active-high.
- `cfg_we`, input, 1: configuration write strobe.
- `cfg_ch`, input, `$clog2(NUM_CH)` (min 1): target channel.
- `cfg_div`, `cfg_high`, `cfg_phase`, input, `CNT_W` each: divide, high count, phase in `clk` cycles.
- `cfg_err`, output, 1: one-cycle pulse when a write is rejected.
- `ps_en`, input, 1: dynamic phase-step request.
- `ps_ch`, input, `$clog2(NUM_CH)`: phase-step channel.
- `ps_incdec`, input, 1: 1 delays the channel by one `clk` cycle; 0 advances it by one cycle.
- `ps_done`, output, 1: one-cycle phase-step completion pulse.
- `clk_out`, output, `NUM_CH`: generated clocks.
- `lock`, output, 1: all channels are aligned and stable.

## Operation
- Per-channel registers: `div`, `high`, `phase`, and counter `cnt` in 0..div-1. Each cycle, `cnt` advances by 1 modulo `div`. Registered `clk_out[i] = (cnt_i < high_i)`.
- Reset values: `div=2`, `high=1`, `phase=0` on every channel; `cnt=0`; `clk_out=0`; `lock=0`; `cfg_err=0`; `ps_done=0`. The first realignment occurs on the first edge after `RST` is released.
- Valid write: `2 ≤ cfg_div`, `1 ≤ cfg_high ≤ cfg_div-1`, `cfg_phase ≤ cfg_div-1`, and `cfg_ch < NUM_CH`.
  - If invalid: `cfg_err` pulses on the next edge, no register changes, and `lock` is unaffected.
  - If valid: the channel registers update and a realignment occurs.
- Realignment (on the accepting edge): every channel loads `cnt = (phase==0) ? 0 : div-phase`, the lock counter clears, and `lock` goes to 0. `lock` returns to 1 after `LOCK_CYCLES` further edges with no realignment.
- Lock states:
  - RUN_UNLOCKED → RUN_LOCKED when the lock counter reaches `LOCK_CYCLES`.
  - Any accepted write, or `PWRDWN` falling, → RUN_UNLOCKED.
  - `PWRDWN` high → PD from any state.
- PD: counters hold, `clk_out=0`, `lock=0`, and writes are still accepted into the registers. Deasserting `PWRDWN` triggers a realignment.
- `cfg_we` during RUN_UNLOCKED restarts alignment and the lock count.

## Timing
- A phase-0 channel's `clk_out` rises 1 edge after realignment. A channel with phase `p` rises at realignment + 1 + p, then every `div` edges, with a high time of `high` edges.
- `cfg_err` and `ps_done` are single-cycle pulses.
- Write-to-new-waveform latency: 1 edge.
- Asserting `RST` mid-operation clears all outputs immediately.

## Configuration
- `CLK_PHASE_GEN_DPS_EN` compiled in: dynamic phase stepping is enabled.
  - A `ps_en` accepted while `lock=1` and no step is pending applies to `ps_ch` on the next edge.
  - Delay step: `cnt` holds for one cycle. Advance step: `cnt += 2` mod `div`.
  - `phase` updates by ±1 mod `div`. `ps_done` pulses 2 edges after `ps_en`.
  - `lock` stays high and there is no realignment.
  - `ps_en` is ignored, with no `ps_done`, when `lock=0`, when a step is pending, when `ps_ch ≥ NUM_CH`, or when `cfg_we` is on the same edge (the write wins).
- Not compiled in: `ps_*` ports remain, `ps_en` is ignored, and `ps_done` is held at 0.

## Test plan
- Reset, then release: all channels toggle 1-high/1-low from edge 1; `lock` rises at edge 1+`LOCK_CYCLES`=65.
- Write ch1 `div=5`, `high=2`, `phase=3`: `lock` drops. Ch0 rises at align+1; ch1 rises at align+4, stays high 2 edges, period 5. `lock` returns after 64 edges.
- Write `div=4`, `high=4`, then write `phase=6` with `div=4`: each produces a `cfg_err` pulse; waveforms and `lock` are unchanged.
- Assert `PWRDWN` for 10 edges: `clk_out=0` and `lock=0`. On release, realignment and a relock after 64 edges.
- DPS enabled, ch0 `div=4`, locked: `ps_en` with `ps_incdec=1` → ch0 edges shift 1 cycle later, `ps_done` 2 edges later, `lock` stays 1. `ps_incdec=0` restores the original timing.
- DPS enabled: `ps_en` and a valid `cfg_we` on the same edge → the write applies, no `ps_done`, and `lock` drops.
